// File: rtl/mor1kx_tlb_reload_arbiter_if.sv
// Page-table-walk memory port shared by the IMMU/DMMU reload arbiter and the LSU/bus bridge.
// The master side is the arbiter; the slave side is the bus bridge that answers each read.
interface mor1kx_tlb_reload_arbiter_if #(
    parameter int OPTION_OPERAND_WIDTH = 32
);
    logic                            bus_req_o;
    logic [OPTION_OPERAND_WIDTH-1:0] bus_addr_o;
    logic                            bus_ack_i;
    logic                            bus_err_i;
    logic [OPTION_OPERAND_WIDTH-1:0] bus_dat_i;

    modport master (
        output bus_req_o,
        output bus_addr_o,
        input  bus_ack_i,
        input  bus_err_i,
        input  bus_dat_i
    );

    modport slave (
        input  bus_req_o,
        input  bus_addr_o,
        output bus_ack_i,
        output bus_err_i,
        output bus_dat_i
    );
endinterface

// File: rtl/mor1kx_tlb_reload_arbiter.sv
// Round-robin arbiter sharing one page-table-walk read port between the IMMU and DMMU reload
// engines; the grant is locked for a whole walk while the owner keeps its req high.
module mor1kx_tlb_reload_arbiter #(
    parameter int OPTION_OPERAND_WIDTH  = 32,
    parameter int OPTION_TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            immu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] immu_addr_i,
    output logic                            immu_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] immu_data_o,
    output logic                            immu_err_o,
    input  logic                            dmmu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_addr_i,
    output logic                            dmmu_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] dmmu_data_o,
    output logic                            dmmu_err_o,
    mor1kx_tlb_reload_arbiter_if.master     bus,
    output logic [1:0]                      grant_o
);
    localparam int OW    = OPTION_OPERAND_WIDTH;
    localparam int CNT_W = (OPTION_TIMEOUT_CYCLES > 0) ? $clog2(OPTION_TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (OPTION_TIMEOUT_CYCLES > 0) ? CNT_W'(OPTION_TIMEOUT_CYCLES - 1) : '0;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;
    localparam logic [1:0] SETTLE = 2'd3;

    localparam logic [1:0] GNT_I = 2'b01;
    localparam logic [1:0] GNT_D = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             rr_prio_q, rr_prio_d;   // 1: DMMU wins a tie
    logic [OW-1:0]    addr_q, addr_d;
    logic [OW-1:0]    idata_q, idata_d;
    logic [OW-1:0]    ddata_q, ddata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             abort_q, abort_d;

    logic          owner_req;
    logic [OW-1:0] owner_addr;
    logic          timeout;
    logic          resp_ok;

    assign owner_req  = (grant_q[0] & immu_req_i) | (grant_q[1] & dmmu_req_i);
    assign owner_addr = grant_q[0] ? immu_addr_i : dmmu_addr_i;
    assign timeout    = (OPTION_TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_prio_d = rr_prio_q;
        addr_d    = addr_q;
        idata_d   = idata_q;
        ddata_d   = ddata_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        abort_d   = abort_q;
        case (state_q)
            IDLE: begin
                if (immu_req_i || dmmu_req_i) begin
                    if (dmmu_req_i && (!immu_req_i || rr_prio_q)) begin
                        grant_d = GNT_D;
                        addr_d  = dmmu_addr_i;
                    end else begin
                        grant_d = GNT_I;
                        addr_d  = immu_addr_i;
                    end
                    state_d = ACCESS;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    abort_d = 1'b0;
                end
            end
            ACCESS: begin
                cnt_d   = cnt_q + CNT_W'(1);
                abort_d = abort_q | ~owner_req;
                // A bus error takes precedence over a simultaneous ack.
                if (bus.bus_err_i || (timeout && !bus.bus_ack_i)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (bus.bus_ack_i) begin
                    state_d = RESP;
                    if (!abort_d) begin
                        if (grant_q[0]) idata_d = bus.bus_dat_i;
                        else            ddata_d = bus.bus_dat_i;
                    end
                end
            end
            RESP: state_d = SETTLE;
            SETTLE: begin
                if (owner_req && !err_q) begin
                    addr_d  = owner_addr;
                    state_d = ACCESS;
                    cnt_d   = '0;
                    abort_d = 1'b0;
                end else begin
                    grant_d   = 2'b00;
                    rr_prio_d = grant_q[0];
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= 2'b00;
            rr_prio_q <= 1'b1;
            addr_q    <= '0;
            idata_q   <= '0;
            ddata_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_prio_q <= rr_prio_d;
            addr_q    <= addr_d;
            idata_q   <= idata_d;
            ddata_q   <= ddata_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            abort_q   <= abort_d;
        end
    end

    // Response pulses come from the single RESP cycle; an abandoned access stays silent.
    assign resp_ok        = (state_q == RESP) && !abort_q;
    assign immu_ack_o     = resp_ok & grant_q[0] & ~err_q;
    assign immu_err_o     = resp_ok & grant_q[0] &  err_q;
    assign dmmu_ack_o     = resp_ok & grant_q[1] & ~err_q;
    assign dmmu_err_o     = resp_ok & grant_q[1] &  err_q;
    assign immu_data_o    = idata_q;
    assign dmmu_data_o    = ddata_q;
    assign bus.bus_req_o  = (state_q == ACCESS);
    assign bus.bus_addr_o = addr_q;
    assign grant_o        = grant_q;
endmodule
